seq_counter_ctrl: RTL and testbench

- Controller that sequences a programmable custom-sequence counter: holds a small table of count codes and steps through it under start/stop/single-step commands.
- Provides a prescaler and a burst length for the stepping rate and run length.
- Table resets to the standard 000 -> 011 -> 101 -> 110 cycle and can be rewritten while the counter is idle or paused.
- Sits between control logic (buttons/FSM) and anything consuming the sequence code.

---
 rtl/seq_ctrl_pkg.sv | 26 ++
 rtl/seq_table.sv | 32 +++
 rtl/seq_counter_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_counter_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and default sequence table for the sequence counter controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [2:0] SEQ0 = 3'b000;
  localparam logic [2:0] SEQ1 = 3'b011;
  localparam logic [2:0] SEQ2 = 3'b101;
  localparam logic [2:0] SEQ3 = 3'b110;

  // Entries beyond the standard four-step cycle reset to zero.
  function automatic logic [2:0] seq_default(input int unsigned i);
    case (i)
      0:       return SEQ0;
      1:       return SEQ1;
      2:       return SEQ2;
      3:       return SEQ3;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seq_table.sv
// Sequence code register file: async reset to the default cycle, one write port,
// one combinational read port that forwards a same-cycle write.
module seq_table
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WIDTH'(seq_default(i));
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/seq_counter_ctrl.sv
// Start/stop/step sequencer over a programmable code table, with prescaler and burst length.
module seq_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PS_W    = 4,
  parameter int unsigned BURST_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_cmd_start,
  input  logic                     i_cmd_stop,
  input  logic                     i_cmd_step,
  input  logic [PS_W-1:0]          i_prescale,
  input  logic [BURST_W-1:0]       i_burst_len,
  input  logic                     i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0] i_cfg_addr,
  input  logic [WIDTH-1:0]         i_cfg_data,
  output logic [WIDTH-1:0]         o_count,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_busy,
  output logic                     o_wrap,
  output logic                     o_done,
  output logic                     o_cfg_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e             r_state, w_state_next;
  logic [AW-1:0]      r_idx, w_idx_next, w_idx_adv;
  logic [PS_W-1:0]    r_psc, w_psc_next, r_ps, w_ps_next;
  logic [BURST_W-1:0] r_rem, w_rem_next;
  logic [WIDTH-1:0]   r_count, w_rdata;
  logic               r_busy, r_wrap, r_done, r_cfg_err;
  logic               w_wrap_next, w_done_next, w_cfg_err_next, w_last, w_tbl_we;

  assign w_last    = (r_idx == AW'(DEPTH - 1));
  assign w_idx_adv = w_last ? '0 : r_idx + 1'b1;
  // Writes are only accepted outside RUN; a RUN write is reported via cfg_err instead.
  assign w_tbl_we  = i_cfg_we && (r_state != ST_RUN);

  seq_table #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_table (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_we     (w_tbl_we),
    .i_waddr  (i_cfg_addr),
    .i_wdata  (i_cfg_data),
    .i_raddr  (w_idx_next),
    .o_rdata  (w_rdata)
  );

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_psc_next     = r_psc;
    w_ps_next      = r_ps;
    w_rem_next     = r_rem;
    w_wrap_next    = 1'b0;
    w_done_next    = 1'b0;
    w_cfg_err_next = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (i_cmd_stop) begin
          w_idx_next = '0;
        end else if (i_cmd_start) begin
          w_state_next = ST_RUN;
          w_psc_next   = '0;
          w_ps_next    = i_prescale;
          if (r_state == ST_IDLE) begin
            w_idx_next = '0;
            w_rem_next = i_burst_len;
          end
        end else if (i_cmd_step) begin
          w_idx_next  = w_idx_adv;
          w_wrap_next = w_last;
        end
      end
      ST_RUN: begin
        w_cfg_err_next = i_cfg_we;
        if (i_cmd_stop) begin
          w_state_next = ST_PAUSE;
          w_psc_next   = '0;
        end else if (r_psc == r_ps) begin
          w_psc_next  = '0;
          w_idx_next  = w_idx_adv;
          w_wrap_next = w_last;
          // rem == 0 means a continuous run; otherwise count down to burst completion.
          if (r_rem == BURST_W'(1)) begin
            w_rem_next   = '0;
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else if (r_rem != '0) begin
            w_rem_next = r_rem - 1'b1;
          end
        end else begin
          w_psc_next = r_psc + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_psc     <= '0;
      r_ps      <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_psc     <= w_psc_next;
      r_ps      <= w_ps_next;
      r_rem     <= w_rem_next;
      r_count   <= w_rdata;
      r_busy    <= (w_state_next == ST_RUN);
      r_wrap    <= w_wrap_next;
      r_done    <= w_done_next;
      r_cfg_err <= w_cfg_err_next;
    end
  end

  assign o_count   = r_count;
  assign o_idx     = r_idx;
  assign o_busy    = r_busy;
  assign o_wrap    = r_wrap;
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: directed scenarios plus random commands, all checked each
// cycle against a cycle-counting behavioural model of the controller.
module tb_seq_counter_ctrl;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_start = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0, cfg_we = 1'b0;
  logic [3:0] prescale = '0;
  logic [7:0] burst_len = '0;
  logic [1:0] cfg_addr = '0;
  logic [2:0] cfg_data = '0;
  logic [2:0] count;
  logic [1:0] idx;
  logic       busy, wrap, done, cfg_err;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  int m_mode, m_idx, m_cnt, m_period, m_rem;
  int m_tbl[4];
  bit m_wrap, m_done, m_err;

  always #5 clk = ~clk;

  seq_counter_ctrl dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_cmd_start(cmd_start),
    .i_cmd_stop (cmd_stop),
    .i_cmd_step (cmd_step),
    .i_prescale (prescale),
    .i_burst_len(burst_len),
    .i_cfg_we   (cfg_we),
    .i_cfg_addr (cfg_addr),
    .i_cfg_data (cfg_data),
    .o_count    (count),
    .o_idx      (idx),
    .o_busy     (busy),
    .o_wrap     (wrap),
    .o_done     (done),
    .o_cfg_err  (cfg_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tbl  = '{0, 3, 5, 6};
    m_mode = MIdle;
    m_idx  = 0;
    m_cnt  = 0;
    m_period = 1;
    m_rem  = 0;
    m_wrap = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic model_advance();
    m_idx  = (m_idx + 1) % 4;
    m_wrap = (m_idx == 0);
  endtask

  // One clock edge of the controller as described in plain terms.
  task automatic model_edge();
    m_wrap = 0;
    m_done = 0;
    m_err  = 0;
    if (m_mode == MRun) begin
      if (cfg_we) m_err = 1;
      if (cmd_stop) begin
        m_mode = MPause;
      end else begin
        m_cnt++;
        if (m_cnt == m_period) begin
          m_cnt = 0;
          model_advance();
          if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
              m_mode = MIdle;
              m_done = 1;
            end
          end
        end
      end
    end else begin
      if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
      if (cmd_stop) begin
        m_idx = 0;
      end else if (cmd_start) begin
        if (m_mode == MIdle) begin
          m_idx = 0;
          m_rem = int'(burst_len);
        end
        m_mode   = MRun;
        m_cnt    = 0;
        m_period = int'(prescale) + 1;
      end else if (cmd_step) begin
        model_advance();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},   int'(count),   m_tbl[m_idx]);
    check({tag, ".idx"},     int'(idx),     m_idx);
    check({tag, ".busy"},    int'(busy),    int'(m_mode == MRun));
    check({tag, ".wrap"},    int'(wrap),    int'(m_wrap));
    check({tag, ".done"},    int'(done),    int'(m_done));
    check({tag, ".cfg_err"}, int'(cfg_err), int'(m_err));
  endtask

  // Called just after a rising edge; drives inputs for the next edge and checks after it.
  task automatic tick(input string tag, input bit st, input bit sp, input bit sk,
                      input bit we, input int a, input int d);
    cmd_start = st;
    cmd_stop  = sp;
    cmd_step  = sk;
    cfg_we    = we;
    cfg_addr  = 2'(a);
    cfg_data  = 3'(d);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset(input string tag);
    cmd_start = 0;
    cmd_stop  = 0;
    cmd_step  = 0;
    cfg_we    = 0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check_all({tag, ".post"});
  endtask

  initial begin
    @(posedge clk);
    #1;
    apply_reset("reset");

    // Continuous run, prescale 0
    prescale = 0;
    burst_len = 0;
    tick("run0", 1, 0, 0, 0, 0, 0);
    idle_ticks("run0", 5);

    // Pause at 101, step, resume with prescale 1
    apply_reset("r1");
    tick("pause", 1, 0, 0, 0, 0, 0);
    idle_ticks("pause", 2);
    check("pause.at101", int'(count), 5);
    tick("pause", 0, 1, 0, 0, 0, 0);
    idle_ticks("pause", 2);
    tick("pause", 0, 0, 1, 0, 0, 0);
    check("pause.step110", int'(count), 6);
    prescale = 1;
    tick("pause", 1, 0, 0, 0, 0, 0);
    idle_ticks("pause", 2);
    check("pause.resume000", int'(count), 0);

    // Burst of 5, prescale 2
    apply_reset("r2");
    prescale = 2;
    burst_len = 5;
    tick("burst", 1, 0, 0, 0, 0, 0);
    idle_ticks("burst", 15);
    check("burst.final011", int'(count), 3);
    idle_ticks("burst", 3);

    // Table rewrite in IDLE, then write attempt during RUN
    apply_reset("r3");
    prescale = 0;
    burst_len = 0;
    tick("cfg", 0, 0, 0, 1, 2, 7);
    tick("cfg", 1, 0, 0, 0, 0, 0);
    idle_ticks("cfg", 3);
    tick("cfg", 0, 0, 0, 1, 1, 0);
    check("cfg.err_pulse", int'(cfg_err), 1);
    idle_ticks("cfg", 4);

    // Stop wins over start in RUN; rewind in PAUSE does not wrap
    tick("prio", 1, 1, 0, 0, 0, 0);
    check("prio.paused", int'(busy), 0);
    tick("prio", 0, 1, 0, 0, 0, 0);
    check("prio.rewind_idx", int'(idx), 0);

    // Write with start from IDLE, address 0 bypass
    apply_reset("r4");
    tick("bypass", 1, 0, 0, 1, 0, 4);
    idle_ticks("bypass", 2);

    // Reset mid-burst restores the default table
    apply_reset("r5");
    prescale = 1;
    burst_len = 20;
    tick("midrst", 0, 0, 0, 1, 2, 7);
    tick("midrst", 1, 0, 0, 0, 0, 0);
    idle_ticks("midrst", 5);
    apply_reset("midrst");
    tick("midrst", 0, 0, 1, 0, 0, 0);
    tick("midrst", 0, 0, 1, 0, 0, 0);
    check("midrst.tbl_revert", int'(count), 5);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) apply_reset("rnd_rst");
      if ($urandom_range(0, 15) == 0) prescale = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        burst_len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      tick("rnd",
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
